// File: rtl/btn_poll_master_if.sv
// rtl/btn_poll_master_if.sv - Avalon-MM read channel between the button poller and the button PIO
interface btn_poll_master_if;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata
    );
endinterface

// File: rtl/btn_poll_master.sv
// rtl/btn_poll_master.sv - periodic Avalon-MM poller of a button PIO with debounce, edge pulses and sticky press IRQ
module btn_poll_master #(
    parameter int WIDTH        = 2,
    parameter int SAMPLE_DIV   = 50000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int READ_LATENCY = 1,
    parameter int INVERT       = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    btn_poll_master_if.master avm,
    output logic [WIDTH-1:0]  btn_state,
    output logic [WIDTH-1:0]  press_pulse,
    output logic [WIDTH-1:0]  release_pulse,
    output logic [WIDTH-1:0]  event_flags,
    output logic              irq,
    input  logic [WIDTH-1:0]  irq_ack
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);
    localparam logic [3:0]       DEB      = 4'(DEBOUNCE_CNT);
    localparam logic [WIDTH-1:0] INV_MASK = (INVERT != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2,
        ST_EVAL = 2'd3
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic             poll_tick;
    logic [LAT_W-1:0] lat_cnt;
    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] candidate;
    logic [3:0]       stable_cnt;

    logic [3:0]       cnt_nxt;
    logic             accept;
    logic             unused_readdata;

    assign poll_tick       = (div_cnt == DIV_LAST);
    assign avm.avm_address = 2'b00;
    assign irq             = |event_flags;
    assign unused_readdata = ^avm.avm_readdata[31:WIDTH];

    // Count the new sample first, then decide on acceptance with the updated count.
    always_comb begin
        cnt_nxt = 4'd1;
        if (sample == candidate) begin
            cnt_nxt = (stable_cnt >= DEB) ? DEB : stable_cnt + 4'd1;
        end
        accept = (cnt_nxt == DEB) && (sample != btn_state);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            div_cnt       <= '0;
            lat_cnt       <= '0;
            sample        <= '0;
            candidate     <= '0;
            stable_cnt    <= '0;
            avm.avm_read  <= 1'b0;
            btn_state     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            event_flags   <= '0;
        end else begin
            div_cnt       <= poll_tick ? '0 : div_cnt + 1'b1;
            press_pulse   <= '0;
            release_pulse <= '0;
            // Set beats clear when a press pulse and an ack hit the same bit.
            event_flags   <= (event_flags & ~irq_ack) | press_pulse;

            case (state)
                ST_IDLE: begin
                    if (poll_tick) begin
                        state        <= ST_READ;
                        avm.avm_read <= 1'b1;
                    end
                end
                ST_READ: begin
                    state        <= ST_WAIT;
                    avm.avm_read <= 1'b0;
                    lat_cnt      <= '0;
                end
                ST_WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        sample <= avm.avm_readdata[WIDTH-1:0] ^ INV_MASK;
                        state  <= ST_EVAL;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_EVAL: begin
                    candidate  <= sample;
                    stable_cnt <= cnt_nxt;
                    if (accept) begin
                        btn_state     <= sample;
                        press_pulse   <= sample & ~btn_state;
                        release_pulse <= ~sample & btn_state;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state        <= ST_IDLE;
                    avm.avm_read <= 1'b0;
                end
            endcase
        end
    end

endmodule
